// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, register ids, status codes and controller FSM state.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage fields from the datapath and the per-stage stall/bubble controls returned to it.
interface pipe_hazard_ctrl_if;

    logic [3:0] D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       e_Cnd;
    logic [3:0] M_icode;
    logic [2:0] m_stat;
    logic [2:0] W_stat;
    logic       mem_busy;

    logic       F_stall;
    logic       D_stall;
    logic       E_stall;
    logic       M_stall;
    logic       W_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       set_cc;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat, mem_busy,
        input  F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat, mem_busy,
        output F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc
    );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard classification from the stage fields: load/use, ret, mispredict, exception.
module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output logic       lu,
    output logic       rt,
    output logic       mp,
    output logic       ex
);

    logic e_is_load;

    assign e_is_load = (E_icode == IMRMOVQ) || (E_icode == IPOPQ);

    // RNONE never matches a real source, so an absent destination cannot raise a load/use stall
    assign lu = e_is_load && (E_dstM != RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign rt = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    assign mp = (E_icode == IJXX) && !e_Cnd;
    assign ex = (m_stat != SAOK) || (W_stat != SAOK);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86 pipeline sequencer: zero-latency per-stage stall/bubble controls plus a run/memwait/halt FSM
// with data-memory timeout and saturating cycle/stall counters.
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    pipe_hazard_ctrl_if.slave   pif,
    output logic                halted,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    cyc_count,
    output logic [CNT_W-1:0]    stall_count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;

    logic lu, rt, mp, ex;
    logic w_fault;
    logic active;
    logic f_stall, d_stall, e_stall, m_stall, w_stall;
    logic d_bubble, e_bubble, m_bubble, cc_we;

    pipe_hazard_detect u_detect (
        .D_icode (pif.D_icode),
        .d_srcA  (pif.d_srcA),
        .d_srcB  (pif.d_srcB),
        .E_icode (pif.E_icode),
        .E_dstM  (pif.E_dstM),
        .e_Cnd   (pif.e_Cnd),
        .M_icode (pif.M_icode),
        .m_stat  (pif.m_stat),
        .W_stat  (pif.W_stat),
        .lu      (lu),
        .rt      (rt),
        .mp      (mp),
        .ex      (ex)
    );

    assign w_fault = (pif.W_stat != SAOK);
    assign active  = (state == ST_RUN) || (state == ST_MEMWAIT);

    // Every state other than free-running RUN freezes the whole pipe, so that is the default.
    always_comb begin
        state_nxt = state;
        f_stall   = 1'b1;
        d_stall   = 1'b1;
        e_stall   = 1'b1;
        m_stall   = 1'b1;
        w_stall   = 1'b1;
        d_bubble  = 1'b0;
        e_bubble  = 1'b0;
        m_bubble  = 1'b0;
        cc_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_fault)           state_nxt = ST_HALT;
                else if (pif.mem_busy) state_nxt = ST_MEMWAIT;
                // A busy memory freezes this very cycle unless W already holds a fault
                if (w_fault || !pif.mem_busy) begin
                    f_stall  = lu | rt;
                    d_stall  = lu;
                    d_bubble = mp | (!lu & rt);
                    e_stall  = 1'b0;
                    e_bubble = mp | lu;
                    m_stall  = 1'b0;
                    m_bubble = ex;
                    w_stall  = w_fault;
                    cc_we    = (pif.E_icode == IOPQ) & !ex;
                end
            end
            ST_MEMWAIT: begin
                if (!pif.mem_busy)            state_nxt = ST_RUN;
                else if (wait_cnt == WAIT_LAST) state_nxt = ST_HALT;
            end
            default: ;
        endcase
    end

    assign pif.F_stall  = f_stall;
    assign pif.D_stall  = d_stall;
    assign pif.E_stall  = e_stall;
    assign pif.M_stall  = m_stall;
    assign pif.W_stall  = w_stall;
    assign pif.D_bubble = d_bubble;
    assign pif.E_bubble = e_bubble;
    assign pif.M_bubble = m_bubble;
    assign pif.set_cc   = cc_we;

    assign halted = (state == ST_HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            cyc_count   <= '0;
            stall_count <= '0;
        end else begin
            state <= state_nxt;

            if (state == ST_MEMWAIT && pif.mem_busy) begin
                if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
                else                       wait_cnt    <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (active) begin
                if (cyc_count != '1)              cyc_count   <= cyc_count + 1'b1;
                if (f_stall && stall_count != '1) stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4) with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             run;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] cyc_count;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl_if pif ();

    pipe_hazard_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .pif         (pif),
        .halted      (halted),
        .mem_timeout (mem_timeout),
        .cyc_count   (cyc_count),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    // {F,D,E,M,W} stalls and {D,E,M} bubbles
    logic [4:0] stl;
    logic [2:0] bub;
    assign stl = {pif.F_stall, pif.D_stall, pif.E_stall, pif.M_stall, pif.W_stall};
    assign bub = {pif.D_bubble, pif.E_bubble, pif.M_bubble};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs are changed and outputs sampled in this window
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic nop_inputs();
        pif.D_icode  = 4'h1;
        pif.d_srcA   = 4'hF;
        pif.d_srcB   = 4'hF;
        pif.E_icode  = 4'h1;
        pif.E_dstM   = 4'hF;
        pif.e_Cnd    = 1'b1;
        pif.M_icode  = 4'h1;
        pif.m_stat   = 3'd1;
        pif.W_stat   = 3'd1;
        pif.mem_busy = 1'b0;
    endtask

    task automatic do_reset_and_run();
        reset = 1'b1;
        run   = 1'b0;
        nop_inputs();
        tick();
        reset = 1'b0;
        run   = 1'b1;
        tick();
        run   = 1'b0;
        settle();
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        nop_inputs();
        tick();
        tick();
        reset = 1'b0;
        settle();

        // Reset / IDLE
        chk("idle_stall",   32'(stl), 32'h1F);
        chk("idle_bubble",  32'(bub), 32'h0);
        chk("idle_setcc",   32'(pif.set_cc), 32'h0);
        chk("idle_halted",  32'(halted), 32'h0);
        chk("idle_cyc",     32'(cyc_count), 32'h0);
        chk("idle_stcnt",   32'(stall_count), 32'h0);
        chk("idle_mto",     32'(mem_timeout), 32'h0);
        tick();
        chk("idle_hold_cyc", 32'(cyc_count), 32'h0);
        run = 1'b1;
        settle();
        chk("idle_run_req_stall", 32'(stl), 32'h1F);
        tick();
        run = 1'b0;
        settle();
        chk("run_nop_stall",  32'(stl), 32'h00);
        chk("run_nop_bubble", 32'(bub), 32'h0);

        // Load/use + ret in D: run cycle 1
        pif.E_icode = 4'h5; pif.E_dstM = 4'h3; pif.d_srcA = 4'h3; pif.D_icode = 4'h9;
        settle();
        chk("lu_ret_stall",  32'(stl), 32'h18);
        chk("lu_ret_bubble", 32'(bub), 32'h2);
        tick();

        // Mispredict + ret: run cycle 2
        pif.E_icode = 4'h7; pif.e_Cnd = 1'b0; pif.E_dstM = 4'hF; pif.d_srcA = 4'hF;
        settle();
        chk("mp_ret_stall",  32'(stl), 32'h10);
        chk("mp_ret_bubble", 32'(bub), 32'h6);
        chk("cnt_after1_cyc", 32'(cyc_count), 32'h1);
        chk("cnt_after1_st",  32'(stall_count), 32'h1);
        tick();

        // Ret only: run cycle 3
        pif.E_icode = 4'h1; pif.e_Cnd = 1'b1;
        settle();
        chk("ret_stall",  32'(stl), 32'h10);
        chk("ret_bubble", 32'(bub), 32'h4);
        tick();

        // OPQ in E sets CC: run cycle 4 (no stall)
        pif.D_icode = 4'h1; pif.E_icode = 4'h6;
        settle();
        chk("opq_setcc", 32'(pif.set_cc), 32'h1);
        chk("opq_stall", 32'(stl), 32'h00);
        chk("cnt_after3_st", 32'(stall_count), 32'h3);
        tick();

        // Memory freeze: busy in RUN (cycle 5) and one MEMWAIT cycle, released on the next
        pif.mem_busy = 1'b1;
        settle();
        chk("busy_run_stall",  32'(stl), 32'h1F);
        chk("busy_run_bubble", 32'(bub), 32'h0);
        chk("busy_run_setcc",  32'(pif.set_cc), 32'h0);
        tick();
        chk("memwait1_stall", 32'(stl), 32'h1F);
        chk("memwait1_setcc", 32'(pif.set_cc), 32'h0);
        tick();
        pif.mem_busy = 1'b0;
        settle();
        chk("memwait2_stall", 32'(stl), 32'h1F);
        chk("memwait2_setcc", 32'(pif.set_cc), 32'h0);
        tick();
        chk("resume_stall", 32'(stl), 32'h00);
        chk("resume_setcc", 32'(pif.set_cc), 32'h1);
        chk("freeze_stcnt", 32'(stall_count), 32'h6);
        chk("freeze_cyc",   32'(cyc_count), 32'h7);
        tick();

        // Timeout: busy from RUN cycle 9, four busy MEMWAIT cycles then HALT
        pif.E_icode  = 4'h1;
        pif.mem_busy = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_halted", 32'(halted), 32'h0);
            chk("to_wait_mto",    32'(mem_timeout), 32'h0);
            tick();
        end
        chk("to_halted", 32'(halted), 32'h1);
        chk("to_mto",    32'(mem_timeout), 32'h1);
        chk("to_stall",  32'(stl), 32'h1F);
        chk("to_cyc",    32'(cyc_count), 32'hD);
        chk("to_stcnt",  32'(stall_count), 32'hB);
        pif.mem_busy = 1'b0;
        tick();
        chk("to_halt_hold", 32'(halted), 32'h1);
        chk("to_cyc_frozen", 32'(cyc_count), 32'hD);

        // Exception path
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rst_mto_clr", 32'(mem_timeout), 32'h0);
        chk("rst_cyc_clr", 32'(cyc_count), 32'h0);
        chk("rst_halt_clr", 32'(halted), 32'h0);
        run = 1'b1;
        tick();
        run = 1'b0;
        pif.m_stat = 3'd3; pif.E_icode = 4'h6;
        settle();
        chk("madr_bubble", 32'(bub), 32'h1);
        chk("madr_setcc",  32'(pif.set_cc), 32'h0);
        chk("madr_stall",  32'(stl), 32'h00);
        tick();
        pif.m_stat = 3'd1; pif.E_icode = 4'h1; pif.W_stat = 3'd3;
        settle();
        chk("wadr_stall",  32'(stl), 32'h01);
        chk("wadr_bubble", 32'(bub), 32'h1);
        chk("wadr_halted", 32'(halted), 32'h0);
        tick();
        chk("exc_halted", 32'(halted), 32'h1);
        chk("exc_stall",  32'(stl), 32'h1F);
        chk("exc_cyc",    32'(cyc_count), 32'h2);
        tick();
        tick();
        chk("exc_cyc_frozen", 32'(cyc_count), 32'h2);
        chk("exc_mto",        32'(mem_timeout), 32'h0);

        // Reset asserted during MEMWAIT
        do_reset_and_run();
        pif.mem_busy = 1'b1;
        tick();
        tick();
        chk("pre_rst_cyc", 32'(cyc_count), 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pif.mem_busy = 1'b0;
        settle();
        chk("mw_rst_cyc", 32'(cyc_count), 32'h0);
        chk("mw_rst_st",  32'(stall_count), 32'h0);
        chk("mw_rst_mto", 32'(mem_timeout), 32'h0);
        tick();
        chk("mw_rst_idle_stall", 32'(stl), 32'h1F);
        chk("mw_rst_idle_cyc",   32'(cyc_count), 32'h0);

        // Counter saturation with a permanent ret stall
        do_reset_and_run();
        pif.D_icode = 4'h9;
        for (int i = 0; i < 14; i++) tick();
        chk("sat14_cyc", 32'(cyc_count), 32'hE);
        chk("sat14_st",  32'(stall_count), 32'hE);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_cyc", 32'(cyc_count), 32'hF);
        chk("sat_st",  32'(stall_count), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
